// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_MASTERS req/gnt/rvalid masters.
// Tracks the owner of the outstanding response and routes rvalid back to it only.
module sp_ram_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_MASTERS-1:0]               m_req_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_addr_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_wdata_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_be_i,
    output logic [NUM_MASTERS-1:0]               m_gnt_o,
    output logic [NUM_MASTERS-1:0]               m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                m_rdata_o,
    output logic                                 mem_req_o,
    output logic                                 mem_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]              mem_be_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i
);

    localparam int          BE_WIDTH  = DATA_WIDTH / 8;
    localparam int          PTR_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned N         = NUM_MASTERS;

    logic [PTR_WIDTH-1:0] rr_ptr;
    logic [PTR_WIDTH-1:0] rsp_owner;
    logic                 rsp_vld;
    logic [PTR_WIDTH-1:0] winner;
    logic [PTR_WIDTH-1:0] sel;
    logic [PTR_WIDTH-1:0] next_ptr;
    logic                 found;
    logic                 active;
    logic                 grant;
    int unsigned          idx;

    // Scan from rr_ptr upward, wrapping modulo N; the first requester wins.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= N) idx = idx - N;
            sel = PTR_WIDTH'(idx);
            if (!found && m_req_i[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

    assign active    = rst_n & (|m_req_i);
    assign grant     = active & mem_gnt_i;
    assign mem_req_o = active;
    assign mem_en_o  = active;
    assign m_rdata_o = mem_rdata_i;
    assign next_ptr  = (winner == PTR_WIDTH'(N - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (active) begin
            mem_addr_o  = m_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_we_o    = m_we_i[winner];
            mem_wdata_o = m_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            mem_be_o    = m_be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];
        end
    end

    always_comb begin
        m_gnt_o = '0;
        if (grant) m_gnt_o[winner] = 1'b1;
    end

    // rst_n gating drops a response issued the cycle before reset asserted.
    always_comb begin
        m_rvalid_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            m_rvalid_o[k] = rst_n & rsp_vld & mem_rvalid_i & (rsp_owner == PTR_WIDTH'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_vld   <= 1'b0;
            rsp_owner <= '0;
        end else if (grant) begin
            rr_ptr    <= next_ptr;
            rsp_vld   <= 1'b1;
            rsp_owner <= winner;
        end else begin
            rsp_vld   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: a 2-master instance against a small RAM model
// driven from a vector table, plus a hand sequence on a 3-master instance.
module tb_sp_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- 2-master instance ----------------
    logic        rst2 = 1'b0;
    logic [1:0]  req2 = '0, we2 = '0;
    logic [15:0] addr2 = '0;
    logic [63:0] wdata2 = '0;
    logic [7:0]  be2 = '0;
    logic [1:0]  gnt2, rv2;
    logic [31:0] rdata2;
    logic        mreq2, men2, mwe2;
    logic [7:0]  maddr2;
    logic [31:0] mwdata2;
    logic [3:0]  mbe2;
    logic        mgnt2 = 1'b1;
    logic        rvf = 1'b0;
    logic        ram_rv = 1'b0;
    logic [31:0] ram_rd = '0;
    logic        mrvalid2;
    logic [31:0] ram [256];
    logic        loaded = 1'b0;

    assign mrvalid2 = ram_rv | rvf;

    sp_ram_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut2 (
        .clk(clk), .rst_n(rst2), .m_req_i(req2), .m_addr_i(addr2), .m_we_i(we2),
        .m_wdata_i(wdata2), .m_be_i(be2), .m_gnt_o(gnt2), .m_rvalid_o(rv2),
        .m_rdata_o(rdata2), .mem_req_o(mreq2), .mem_en_o(men2), .mem_addr_o(maddr2),
        .mem_we_o(mwe2), .mem_wdata_o(mwdata2), .mem_be_o(mbe2), .mem_gnt_i(mgnt2),
        .mem_rvalid_i(mrvalid2), .mem_rdata_i(ram_rd)
    );

    // RAM model: one word per address, response one cycle after an accepted request.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 | 32'(i);
            ram[8'h10] <= 32'h1234_5678;
            ram[8'h20] <= 32'h1122_3344;
            loaded <= 1'b1;
            ram_rv <= 1'b0;
        end else begin
            ram_rv <= mreq2 & mgnt2;
            if (mreq2 && mgnt2) begin
                if (mwe2) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe2[b]) ram[maddr2][b*8 +: 8] <= mwdata2[b*8 +: 8];
                    ram_rd <= '0;
                end else begin
                    ram_rd <= ram[maddr2];
                end
            end
        end
    end

    // ---------------- 3-master instance ----------------
    logic        rst3 = 1'b0;
    logic [2:0]  req3 = '0;
    logic [23:0] addr3 = {8'h22, 8'h11, 8'h00};
    logic [2:0]  gnt3, rv3;
    logic [31:0] rdata3;
    logic        mreq3, men3, mwe3;
    logic [7:0]  maddr3;
    logic [31:0] mwdata3;
    logic [3:0]  mbe3;
    logic        mrv3 = 1'b0;

    always @(posedge clk) mrv3 <= mreq3;

    sp_ram_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut3 (
        .clk(clk), .rst_n(rst3), .m_req_i(req3), .m_addr_i(addr3), .m_we_i(3'b000),
        .m_wdata_i(96'h0), .m_be_i(12'hFFF), .m_gnt_o(gnt3), .m_rvalid_o(rv3),
        .m_rdata_o(rdata3), .mem_req_o(mreq3), .mem_en_o(men3), .mem_addr_o(maddr3),
        .mem_we_o(mwe3), .mem_wdata_o(mwdata3), .mem_be_o(mbe3), .mem_gnt_i(1'b1),
        .mem_rvalid_i(mrv3), .mem_rdata_i(32'h0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        g;
        logic        rvf;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [1:0]  egnt;
        logic [1:0]  erv;
        logic [31:0] erd;
        logic        crd;
        logic [7:0]  emaddr;
    } vec_t;

    function automatic vec_t mk(input logic rst, g, rf, input logic [1:0] req, we,
                                input logic [7:0] a0, a1, input logic [31:0] wd,
                                input logic [3:0] be, input logic [1:0] egnt, erv,
                                input logic [31:0] erd, input logic crd,
                                input logic [7:0] emaddr);
        vec_t v;
        v.rst = rst; v.g = g; v.rvf = rf; v.req = req; v.we = we; v.a0 = a0; v.a1 = a1;
        v.wd = wd; v.be = be; v.egnt = egnt; v.erv = erv; v.erd = erd; v.crd = crd;
        v.emaddr = emaddr;
        return v;
    endfunction

    task automatic step3(input logic rst, input logic [2:0] req, input logic [2:0] egnt,
                         input logic [2:0] erv, input logic [7:0] emaddr, input int n);
        @(posedge clk); #1;
        rst3 = rst; req3 = req;
        @(negedge clk);
        chk($sformatf("m3 s%0d gnt", n), 32'(gnt3), 32'(egnt));
        chk($sformatf("m3 s%0d rvalid", n), 32'(rv3), 32'(erv));
        chk($sformatf("m3 s%0d mem_addr", n), 32'(maddr3), 32'(emaddr));
        chk($sformatf("m3 s%0d mem_req", n), 32'(mreq3), 32'(rst & (|req)));
    endtask

    vec_t vecs[23];

    initial begin
        //           rst g rvf req    we     a0     a1     wd            be    egnt   erv    erd           crd emaddr
        vecs[0]  = mk(0, 1, 0, 2'b11, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b00, 2'b00, 32'h0,        0, 8'h00);
        vecs[1]  = mk(0, 1, 0, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b00, 2'b00, 32'h0,        0, 8'h00);
        vecs[2]  = mk(1, 1, 0, 2'b01, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b01, 2'b00, 32'h0,        0, 8'h10);
        vecs[3]  = mk(1, 1, 0, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b00, 2'b01, 32'h12345678, 1, 8'h00);
        vecs[4]  = mk(1, 1, 0, 2'b10, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b10, 2'b00, 32'h0,        0, 8'h30);
        vecs[5]  = mk(1, 1, 0, 2'b11, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b01, 2'b10, 32'hA0000030, 1, 8'h10);
        vecs[6]  = mk(1, 1, 0, 2'b11, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b10, 2'b01, 32'h12345678, 1, 8'h30);
        vecs[7]  = mk(1, 1, 0, 2'b11, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b01, 2'b10, 32'hA0000030, 1, 8'h10);
        vecs[8]  = mk(1, 1, 0, 2'b11, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b10, 2'b01, 32'h12345678, 1, 8'h30);
        vecs[9]  = mk(1, 1, 0, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b00, 2'b10, 32'hA0000030, 1, 8'h00);
        vecs[10] = mk(1, 1, 0, 2'b10, 2'b10, 8'h20, 8'h20, 32'hAABBCCDD, 4'h3, 2'b10, 2'b00, 32'h0,        0, 8'h20);
        vecs[11] = mk(1, 1, 0, 2'b01, 2'b00, 8'h20, 8'h20, 32'hAABBCCDD, 4'h3, 2'b01, 2'b10, 32'h0,        0, 8'h20);
        vecs[12] = mk(1, 1, 0, 2'b00, 2'b00, 8'h20, 8'h20, 32'h0,        4'hF, 2'b00, 2'b01, 32'h1122CCDD, 1, 8'h00);
        vecs[13] = mk(1, 0, 0, 2'b11, 2'b00, 8'h10, 8'h40, 32'h0,        4'hF, 2'b00, 2'b00, 32'h0,        0, 8'h40);
        vecs[14] = mk(1, 0, 0, 2'b11, 2'b00, 8'h10, 8'h40, 32'h0,        4'hF, 2'b00, 2'b00, 32'h0,        0, 8'h40);
        vecs[15] = mk(1, 0, 0, 2'b11, 2'b00, 8'h10, 8'h40, 32'h0,        4'hF, 2'b00, 2'b00, 32'h0,        0, 8'h40);
        vecs[16] = mk(1, 1, 0, 2'b11, 2'b00, 8'h10, 8'h40, 32'h0,        4'hF, 2'b10, 2'b00, 32'h0,        0, 8'h40);
        vecs[17] = mk(1, 1, 0, 2'b11, 2'b00, 8'h10, 8'h40, 32'h0,        4'hF, 2'b01, 2'b10, 32'hA0000040, 1, 8'h10);
        vecs[18] = mk(1, 1, 0, 2'b10, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b10, 2'b01, 32'h12345678, 1, 8'h30);
        vecs[19] = mk(0, 1, 0, 2'b11, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b00, 2'b00, 32'h0,        0, 8'h00);
        vecs[20] = mk(1, 1, 1, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b00, 2'b00, 32'h0,        0, 8'h00);
        vecs[21] = mk(1, 1, 0, 2'b11, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b01, 2'b00, 32'h0,        0, 8'h10);
        vecs[22] = mk(1, 1, 0, 2'b00, 2'b00, 8'h10, 8'h30, 32'h0,        4'hF, 2'b00, 2'b01, 32'h12345678, 1, 8'h00);

        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            rst2   = vecs[i].rst;
            mgnt2  = vecs[i].g;
            rvf    = vecs[i].rvf;
            req2   = vecs[i].req;
            we2    = vecs[i].we;
            addr2  = {vecs[i].a1, vecs[i].a0};
            wdata2 = {vecs[i].wd, vecs[i].wd};
            be2    = {vecs[i].be, vecs[i].be};
            @(negedge clk);
            chk($sformatf("v%0d gnt", i), 32'(gnt2), 32'(vecs[i].egnt));
            chk($sformatf("v%0d rvalid", i), 32'(rv2), 32'(vecs[i].erv));
            chk($sformatf("v%0d mem_req", i), 32'(mreq2), 32'(vecs[i].rst & (|vecs[i].req)));
            chk($sformatf("v%0d mem_en", i), 32'(men2), 32'(vecs[i].rst & (|vecs[i].req)));
            chk($sformatf("v%0d mem_addr", i), 32'(maddr2), 32'(vecs[i].emaddr));
            if (vecs[i].crd) chk($sformatf("v%0d rdata", i), rdata2, vecs[i].erd);
        end

        // 3 masters: m0 and m2 contend from rr_ptr=1, then reset must return rr_ptr to 0.
        step3(0, 3'b000, 3'b000, 3'b000, 8'h00, 0);
        step3(0, 3'b000, 3'b000, 3'b000, 8'h00, 1);
        step3(1, 3'b001, 3'b001, 3'b000, 8'h00, 2);
        step3(1, 3'b101, 3'b100, 3'b001, 8'h22, 3);
        step3(1, 3'b101, 3'b001, 3'b100, 8'h00, 4);
        step3(1, 3'b101, 3'b100, 3'b001, 8'h22, 5);
        step3(1, 3'b101, 3'b001, 3'b100, 8'h00, 6);
        step3(0, 3'b101, 3'b000, 3'b000, 8'h00, 7);
        step3(1, 3'b101, 3'b001, 3'b000, 8'h00, 8);
        step3(1, 3'b000, 3'b000, 3'b001, 8'h00, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
